// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Iterative multiply/divide sequencer that owns the HI/LO register pair of the
// MIPS CPU. MULT/MULTU/DIV/DIVU run one bit per cycle on operand magnitudes
// (shift-add multiply, restoring divide). A final fix-up cycle applies the
// sign correction and writes HI/LO. busy stalls HI/LO users and the next
// mul/div until the result lands; done pulses for one cycle when it has.
//
// Ports
//   clk     system clock
//   reset   synchronous, active-high reset (abandons any op, clears HI/LO)
//   start   launch op; sampled only while busy=0
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  multiplicand / dividend
//   rt_val  multiplier / divisor
//   mthi    write wdata to HI (ignored while busy or when start is high)
//   mtlo    write wdata to LO (ignored while busy or when start is high)
//   wdata   MTHI/MTLO data
//   busy    operation in flight
//   done    one-cycle pulse: HI/LO hold the new result
//   hi      HI register (remainder / product upper half)
//   lo      LO register (quotient / product lower half)
//
// Build option
//   MULDIV_FAST_DIVZERO_EN : DIV/DIVU with rt_val=0 skips the iterations and
//   goes straight to the fix-up cycle (done two cycles after start). The
//   HI/LO values are the same as the full-length sequence produces.
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   // Multiply: {partial product upper half, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
   logic [2*WIDTH-1:0]   acc_reg, acc_next;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [WIDTH-1:0]     opnd_reg, opnd_next;
   logic                 is_div_reg, is_div_next;
   logic                 neg_res_reg, neg_res_next;
   logic                 neg_rem_reg, neg_rem_next;
   logic                 done_reg, done_next;
   logic [WIDTH-1:0]     hi_reg, hi_next;
   logic [WIDTH-1:0]     lo_reg, lo_next;

   // Operand magnitudes (signed ops only; unsigned ops pass raw values).
   logic                 signed_op;
   logic                 rs_neg, rt_neg;
   logic [WIDTH-1:0]     rs_mag, rt_mag;

   // One iteration of each datapath.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_step;
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       rem_diff;
   logic [2*WIDTH-1:0]   div_step;

   // Sign-corrected results.
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign signed_op = ~op[0];
   assign rs_neg    = signed_op & rs_val[WIDTH-1];
   assign rt_neg    = signed_op & rt_val[WIDTH-1];
   assign rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
   assign rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;

   // Shift-add: add the multiplicand into the upper half when the current
   // multiplier LSB is set, then shift the whole accumulator right, keeping
   // the carry out of the add as the new MSB.
   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
   assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

   // Restoring divide: bring the next dividend bit into the remainder and try
   // to subtract the divisor. The remainder stays below the divisor, so the
   // shifted value fits WIDTH+1 bits and bit WIDTH of the difference is an
   // exact "went negative" flag.
   assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, opnd_reg};
   assign div_step  = rem_diff[WIDTH]
                    ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                    : {rem_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

   // A divisor of zero naturally yields quotient all-ones and remainder equal
   // to the dividend magnitude, which after sign fix-up gives hi=rs_val.
   assign prod_fix = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
   assign quo_fix  = neg_res_reg ? (~acc_reg[WIDTH-1:0] + 1'b1)
                                 : acc_reg[WIDTH-1:0];
   assign rem_fix  = neg_rem_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                                 : acc_reg[2*WIDTH-1:WIDTH];

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      acc_next     = acc_reg;
      opnd_next    = opnd_reg;
      is_div_next  = is_div_reg;
      neg_res_next = neg_res_reg;
      neg_rem_next = neg_rem_reg;
      done_next    = 1'b0;
      hi_next      = hi_reg;
      lo_next      = lo_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               is_div_next  = op[1];
               neg_res_next = rs_neg ^ rt_neg;
               neg_rem_next = rs_neg;
               cnt_next     = CW'(WIDTH);
               state_next   = ST_ITER;
               if (op[1]) begin
                  acc_next  = {{WIDTH{1'b0}}, rs_mag};
                  opnd_next = rt_mag;
`ifdef MULDIV_FAST_DIVZERO_EN
                  if (rt_val == '0) begin
                     // Preload what the iterations would have produced.
                     acc_next   = {rs_mag, {WIDTH{1'b1}}};
                     state_next = ST_FIX;
                  end
`endif
               end else begin
                  acc_next  = {{WIDTH{1'b0}}, rt_mag};
                  opnd_next = rs_mag;
               end
            end else begin
               // start has priority; MTHI/MTLO only land when no op launches.
               if (mthi) begin
                  hi_next = wdata;
               end
               if (mtlo) begin
                  lo_next = wdata;
               end
            end
         end

         ST_ITER: begin
            acc_next = is_div_reg ? div_step : mul_step;
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
               state_next = ST_FIX;
            end
         end

         ST_FIX: begin
            if (is_div_reg) begin
               hi_next = rem_fix;
               lo_next = quo_fix;
            end else begin
               hi_next = prod_fix[2*WIDTH-1:WIDTH];
               lo_next = prod_fix[WIDTH-1:0];
            end
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         opnd_reg    <= '0;
         is_div_reg  <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         done_reg    <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         acc_reg     <= acc_next;
         opnd_reg    <= opnd_next;
         is_div_reg  <= is_div_next;
         neg_res_reg <= neg_res_next;
         neg_rem_reg <= neg_rem_next;
         done_reg    <= done_next;
         hi_reg      <= hi_next;
         lo_reg      <= lo_next;
      end
   end

   assign busy = (state_reg != ST_IDLE);
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule
